// File: rtl/watchdog_timer.sv
// watchdog_timer: armed down-counter that issues a fixed-length reset request when not kicked in time
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset (leaves o_timeout_flag untouched)
//   i_enable       1 arms, 0 disarms
//   i_kick         service strobe, reloads the counter from i_timeout
//   i_timeout      reload value in clocks, sampled on arm and on every kick
//   i_flag_clr     clears the sticky timeout flag
//   o_wdt_reset    registered reset request, PULSE_CYCLES clocks long
//   o_warn         registered, high while armed with count <= WARN_CYCLES
//   o_timeout_flag sticky reset-cause flag
//   o_count        current counter value
module watchdog_timer #(
    parameter int CNT_W        = 16,
    parameter int WARN_CYCLES  = 256,
    parameter int PULSE_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_kick,
    input  logic [CNT_W-1:0] i_timeout,
    input  logic             i_flag_clr,
    output logic             o_wdt_reset,
    output logic             o_warn,
    output logic             o_timeout_flag,
    output logic [CNT_W-1:0] o_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WARN, S_FIRE} state_t;
    localparam logic [7:0] PULSE_V = 8'(PULSE_CYCLES - 1);
    // Power-up values come from the declaration initialisers; i_reset never touches flag.
    state_t           state = S_IDLE;
    state_t           state_d;
    logic [CNT_W-1:0] count = '0;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] dec;
    logic [7:0]       pulse = '0;
    logic [7:0]       pulse_d;
    logic             warn = 1'b0;
    logic             wdt = 1'b0;
    logic             flag = 1'b0;
    logic             fire;
    function automatic logic in_warn(input logic [CNT_W-1:0] v);
        return 32'(v) <= 32'(WARN_CYCLES);
    endfunction
    assign dec = (count == '0) ? '0 : count - 1'b1;
    always_comb begin
        state_d = state;
        count_d = count;
        pulse_d = pulse;
        case (state)
            S_IDLE: begin
                count_d = '0;
                if (i_enable && i_timeout != '0) begin
                    count_d = i_timeout;
                    state_d = in_warn(i_timeout) ? S_WARN : S_RUN;
                end
            end
            S_RUN, S_WARN: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (i_kick) begin
                    count_d = i_timeout;
                    state_d = in_warn(i_timeout) ? S_WARN : S_RUN;
                end else if (count == '0) begin
                    state_d = S_FIRE;
                    pulse_d = PULSE_V;
                end else begin
                    count_d = dec;
                    state_d = in_warn(dec) ? S_WARN : S_RUN;
                end
            end
            S_FIRE: begin
                // Leaving goes to idle only; arming is re-evaluated on the following clock.
                count_d = '0;
                state_d = (pulse == '0) ? S_IDLE : S_FIRE;
                pulse_d = (pulse == '0) ? '0 : pulse - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
                pulse_d = '0;
            end
        endcase
    end
    assign fire = (state_d == S_FIRE) && (state != S_FIRE);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            count <= '0;
            pulse <= '0;
            warn  <= 1'b0;
            wdt   <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            pulse <= pulse_d;
            warn  <= state_d == S_WARN;
            wdt   <= state_d == S_FIRE;
            flag  <= fire | (flag & ~i_flag_clr);
        end
    end
    assign o_wdt_reset    = wdt;
    assign o_warn         = warn;
    assign o_timeout_flag = flag;
    assign o_count        = count;
endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the counter and timeout width in bits.
REQ-002 SHALL have parameter WARN_CYCLES, default 256, giving the remaining-count threshold for the warning output.
REQ-003 SHALL have parameter PULSE_CYCLES, default 32, giving the reset-request pulse length in clocks (range 1..255).
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset (driven from the reset manager's o_reset).
REQ-006 i_enable  input  1  level; 1 arms the watchdog, 0 disarms it.
REQ-007 i_kick  input  1  service strobe; each clock it is high, the counter reloads.
REQ-008 i_timeout  input  CNT_W  reload value in clocks, sampled on arm and on every kick.
REQ-009 i_flag_clr  input  1  clears the sticky timeout flag.
REQ-010 o_wdt_reset  output  1  registered reset request to the reset manager's i_areset.
REQ-011 o_warn  output  1  registered; high while armed and the count is <= WARN_CYCLES.
REQ-012 o_timeout_flag  output  1  sticky reset-cause flag.
REQ-013 o_count  output  CNT_W  current counter value.

Function
REQ-014 SHALL implement states S_IDLE, S_RUN, S_WARN and S_FIRE; unused encodings go to S_IDLE on the next edge.
REQ-015 S_IDLE: o_count=0, o_warn=0, o_wdt_reset=0; if i_enable=1 and i_timeout!=0, load count=i_timeout and go to S_RUN, or to S_WARN if i_timeout<=WARN_CYCLES; i_timeout=0 keeps the block in S_IDLE.
REQ-016 S_RUN/S_WARN: count decrements by 1 per clock and saturates at 0, with no wrap-around.
REQ-017 S_RUN/S_WARN kick: i_kick=1 loads count=i_timeout on that edge; kick beats decrement; state becomes S_WARN if i_timeout<=WARN_CYCLES, else S_RUN.
REQ-018 S_RUN -> S_WARN on the edge where the new count is <= WARN_CYCLES; o_warn is high exactly while in S_WARN.
REQ-019 S_RUN/S_WARN disarm: i_enable=0 goes to S_IDLE on the next edge and has priority over kick and expiry.
REQ-020 Expiry: count=0 with i_enable=1 and i_kick=0 moves to S_FIRE on that edge, sets o_wdt_reset=1, o_warn=0 and o_timeout_flag=1.
REQ-021 Kick in the same cycle as count=0 SHALL reload and SHALL NOT fire.
REQ-022 Timing: with arm at edge 0, value T and no kicks, count=T-k after edge k, count=0 after edge T, and o_wdt_reset rises after edge T+1.
REQ-023 S_FIRE: o_wdt_reset stays high for exactly PULSE_CYCLES clocks, then the block returns to S_IDLE with o_wdt_reset=0.
REQ-024 S_FIRE ignores i_kick and i_enable; o_count holds 0.
REQ-025 o_timeout_flag: set on S_FIRE entry; cleared only by i_flag_clr=1 (next edge); set has priority when set and clear occur together.
REQ-026 The block SHALL NOT re-arm on the same edge it leaves S_FIRE; the S_IDLE arm rule applies from the following clock.

Reset
REQ-027 i_reset=1 SHALL force S_IDLE, count=0, o_warn=0 and o_wdt_reset=0 on the next edge, including mid-pulse in S_FIRE (pulse truncated).
REQ-028 i_reset SHALL NOT clear o_timeout_flag, so the reset cause survives the reset it caused.
REQ-029 Power-up initial values: state S_IDLE, all outputs 0, including o_timeout_flag.
REQ-030 i_reset has priority over every other input.

Verification
REQ-031 Arm T=100, WARN_CYCLES=16, PULSE_CYCLES=32, no kicks -> o_warn rises after edge 84; o_wdt_reset high after edges 101..132; o_timeout_flag=1.
REQ-032 Same setup, kick every 50 clocks for 10000 clocks -> o_wdt_reset never rises; o_warn stays 0; after each kick edge o_count=100.
REQ-033 Kick coincident with count=0 -> no fire; count=100 next clock. Then disarm (i_enable=0) at count=5 -> S_IDLE, o_count=0, no fire.
REQ-034 i_reset asserted 10 clocks into the fire pulse -> o_wdt_reset=0 next edge; o_timeout_flag stays 1; i_flag_clr pulse -> 0; i_flag_clr coincident with expiry -> flag ends 1.
REQ-035 i_timeout=0 with i_enable=1 -> remains S_IDLE indefinitely. i_timeout=8 (<=WARN_CYCLES) -> o_warn=1 from arm; o_wdt_reset rises after edge 9.
